// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
// Runs one operation at a time. Normal ops take 32 shift steps: a shift-add
// multiply or a restoring divide. Divide-by-zero and signed overflow skip
// the iteration and finish in one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, accepted only while idle
//   funct3            0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rd                destination register index
//   rs1_val, rs2_val  operands (dividend/multiplicand, divisor/multiplier)
//   busy              high in CALC and DONE
//   done              one-cycle completion pulse
//   result            registered result, held until the next completion
//   wr_addr           captured rd
//   wr_en             register-file write strobe (never for x0)
module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter int CNT_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          funct3,
   input  logic [4:0]          rd,
   input  logic [XLEN-1:0]     rs1_val,
   input  logic [XLEN-1:0]     rs2_val,
   output logic                busy,
   output logic                done,
   output logic [XLEN-1:0]     result,
   output logic [4:0]          wr_addr,
   output logic                wr_en
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [2:0]          op;
   logic [CNT_BITS-1:0] cnt;
   logic [XLEN-1:0]     acc_hi, acc_lo;  // mul: product hi/lo; div: remainder/quotient
   logic [XLEN-1:0]     opnd;            // mul: multiplicand; div: divisor
   logic                neg;

   // ---- accept-side decode ----
   logic            sgn1, sgn2, s1, s2, fast, div_zero, div_ovf, neg_in;
   logic [XLEN-1:0] mag1, mag2, fast_res;

   always_comb begin
      sgn1     = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
      sgn2     = funct3 inside {3'd1, 3'd4, 3'd6};
      s1       = sgn1 & rs1_val[XLEN-1];
      s2       = sgn2 & rs2_val[XLEN-1];
      mag1     = s1 ? -rs1_val : rs1_val;
      mag2     = s2 ? -rs2_val : rs2_val;
      // REM/REMU take the dividend's sign; everything else takes s1^s2
      neg_in   = (funct3[2] & funct3[1]) ? s1 : (s1 ^ s2);
      div_zero = (rs2_val == '0);
      div_ovf  = ~funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);
      fast     = funct3[2] & (div_zero | div_ovf);
      if (div_zero)
         fast_res = funct3[1] ? rs1_val : '1;
      else
         fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // ---- one iteration step ----
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic              div_ok;
   logic [XLEN-1:0]   step_hi, step_lo, div_val, fin_res;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_sh   = {acc_hi, acc_lo[XLEN-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_ok   = ~div_diff[XLEN];
      if (op[2]) begin
         step_hi = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
         step_lo = {acc_lo[XLEN-2:0], div_ok};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
      // final sign correction applied to the last step's outcome
      prod    = {step_hi, step_lo};
      prod    = neg ? -prod : prod;
      div_val = op[1] ? step_hi : step_lo;
      div_val = neg ? -div_val : div_val;
      if (op[2])
         fin_res = div_val;
      else if (op[1:0] == 2'd0)
         fin_res = prod[XLEN-1:0];
      else
         fin_res = prod[2*XLEN-1:XLEN];
   end

   // ---- FSM ----
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = fast ? DONE : CALC;
         CALC:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- datapath ----
   always_ff @(posedge clk) begin
      if (rst) begin
         op      <= '0;
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         neg     <= 1'b0;
         result  <= '0;
         wr_addr <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op      <= funct3;
               wr_addr <= rd;
               cnt     <= '1;
               neg     <= neg_in;
               if (fast) begin
                  result <= fast_res;
               end else begin
                  acc_hi <= '0;
                  acc_lo <= funct3[2] ? mag1 : mag2;
                  opnd   <= funct3[2] ? mag2 : mag1;
               end
            end
            CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               if (cnt == '0) result <= fin_res;
               else           cnt    <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign wr_en = done & (wr_addr != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table driven through a
// scoreboard queue, plus hand-written back-pressure and reset-abort runs.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] rs1_val, rs2_val;
   logic        busy, done, wr_en;
   logic [31:0] result;
   logic [4:0]  wr_addr;

   muldiv_unit #(.XLEN(32), .CNT_BITS(5)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rd(rd),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy), .done(done),
      .result(result), .wr_addr(wr_addr), .wr_en(wr_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] a, b, exp;
      int          lat;   // negedges after the accept edge until done is seen
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  addr;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   nvec = 0;
   int   nmis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Drive one op, push its expectation, wait for done (bounded), pop and compare.
   // poke=1 also pulses start mid-flight (sampled at E5) and in the DONE cycle.
   task automatic run_op(input vec_t v, input bit poke);
      exp_t e;
      int   n;
      int   stray;
      bit   got;
      @(negedge clk);
      funct3 = v.f3; rd = v.rd; rs1_val = v.a; rs2_val = v.b; start = 1'b1;
      sb.push_back('{v.exp, v.rd, v.lat});
      got = 1'b0;
      n   = 0;
      while (n <= 40 && !got) begin
         @(negedge clk);
         start = 1'b0;
         if (poke && n == 4) begin
            start = 1'b1; funct3 = 3'd4; rd = 5'd9;
            rs1_val = $urandom; rs2_val = 32'd3;
         end
         if (done) got = 1'b1;
         else      n++;
      end
      e = sb.pop_front();
      if (!got) begin
         nvec++; nmis++;
         $display("FAIL timeout: no done for funct3=%0d a=%h b=%h want %h", v.f3, v.a, v.b, e.res);
      end else begin
         chk("result",  result, e.res);
         chk("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
         chk("wr_en",   {31'b0, wr_en}, {31'b0, (e.addr != 5'd0)});
         chk("latency", n, e.lat);
         chk("busy_in_done", {31'b0, busy}, 32'd1);
      end
      if (poke) begin
         start = 1'b1; funct3 = 3'd7; rd = 5'd2;
         rs1_val = 32'd50; rs2_val = 32'd6;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("busy_after",     {31'b0, busy}, 32'd0);
      if (poke) begin
         stray = 0;
         repeat (40) begin
            @(negedge clk);
            if (done || busy) stray++;
         end
         chk("stray_activity", stray, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   stray;

      vecs.push_back('{3'd0, 5'd5,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32});
      vecs.push_back('{3'd1, 5'd6,  32'h80000000, 32'h80000000, 32'h40000000, 32});
      vecs.push_back('{3'd3, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
      vecs.push_back('{3'd2, 5'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32});
      vecs.push_back('{3'd1, 5'd9,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32});
      vecs.push_back('{3'd0, 5'd10, 32'h12345678, 32'h00000010, 32'h23456780, 32});
      vecs.push_back('{3'd3, 5'd11, 32'h12345678, 32'h00000010, 32'h00000001, 32});
      vecs.push_back('{3'd4, 5'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32});
      vecs.push_back('{3'd6, 5'd13, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32});
      vecs.push_back('{3'd5, 5'd14, 32'd100,      32'd7,        32'd14,       32});
      vecs.push_back('{3'd7, 5'd15, 32'd100,      32'd7,        32'd2,        32});
      vecs.push_back('{3'd4, 5'd16, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32});
      vecs.push_back('{3'd6, 5'd17, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32});
      vecs.push_back('{3'd4, 5'd18, 32'h80000000, 32'h00000002, 32'hC0000000, 32});
      vecs.push_back('{3'd5, 5'd19, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32});
      vecs.push_back('{3'd4, 5'd20, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{3'd6, 5'd21, 32'd5,        32'd0,        32'd5,        0});
      vecs.push_back('{3'd4, 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
      vecs.push_back('{3'd6, 5'd23, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0});
      vecs.push_back('{3'd5, 5'd24, 32'd7,        32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{3'd7, 5'd25, 32'd7,        32'd0,        32'd7,        0});
      vecs.push_back('{3'd0, 5'd0,  32'd3,        32'd4,        32'd12,       32});

      rst = 1'b1; start = 1'b0; funct3 = '0; rd = '0; rs1_val = '0; rs2_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",    {31'b0, busy},  32'd0);
      chk("rst_done",    {31'b0, done},  32'd0);
      chk("rst_wr_en",   {31'b0, wr_en}, 32'd0);
      chk("rst_result",  result, 32'd0);
      chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i], 1'b0);

      // start pulses mid-flight and in DONE must be ignored
      v = '{3'd0, 5'd1, 32'h00001234, 32'h00000100, 32'h00123400, 32};
      run_op(v, 1'b1);

      // reset at E10 of a DIVU aborts it with no write-back
      @(negedge clk);
      funct3 = 3'd5; rd = 5'd3; rs1_val = 32'd1000; rs2_val = 32'd7; start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 9) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",    {31'b0, busy},  32'd0);
      chk("abort_done",    {31'b0, done},  32'd0);
      chk("abort_wr_en",   {31'b0, wr_en}, 32'd0);
      chk("abort_result",  result, 32'd0);
      chk("abort_wr_addr", {27'b0, wr_addr}, 32'd0);
      stray = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || wr_en || busy) stray++;
      end
      chk("abort_no_write", stray, 0);

      v = '{3'd5, 5'd4, 32'd9, 32'd3, 32'd3, 32};
      run_op(v, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
